// File: rtl/spi_pkg.sv
// Shared encodings, widths and the transmit-load helper for the SPI slave.
package spi_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [BYTE_W-1:0] FILL_BYTE = 8'h00;

  // Byte presented to the shifter on a load: buffered data, or filler when empty.
  function automatic logic [BYTE_W-1:0] load_byte(input logic full,
                                                  input logic [BYTE_W-1:0] data);
    return full ? data : FILL_BYTE;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous line with registered rise/fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  assign level = sync_p0[SYNC_STAGES-1];

  // Resetting to the idle line level keeps a quiet line from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= {SYNC_STAGES{RESET_VAL}};
      prev_p1 <= RESET_VAL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      prev_p1 <= level;
      rise    <= level & ~prev_p1;
      fall    <= ~level & prev_p1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversampled serial lines, one-byte transmit buffer, byte receive.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  logic                   sclk_level, sclk_rise, sclk_fall;
  logic                   cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic [0:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [BYTE_W-1:0]      rx_shift;
  logic [BYTE_W-1:0]      tx_shift;
  logic [BYTE_W-1:0]      buf_data;
  logic                   buf_full;
  logic                   armed;
  logic [1:0]             settle;
  logic                   vld_p1;

  logic                   start;
  logic                   byte_end;
  logic                   load;
  logic                   wr;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // A frame may only open once cs has genuinely been seen high after reset,
  // so a cs held low through reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_level) armed <= 1'b1;
    end
  end

  always_comb begin
    start    = (state == IDLE) && cs_fall && armed && !sclk_level;
    byte_end = (state == SHIFT) && !cs_rise && sclk_rise &&
               (bit_cnt == {CNT_W{1'b1}});
    load     = start | byte_end;
    wr       = tx_valid & ~buf_full;
  end

  // Transmit buffer: a write into an empty buffer is never bypassed into a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      buf_full    <= wr | (buf_full & ~load);
      tx_underrun <= load & ~buf_full;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) buf_data <= tx_data;
  end

  // Stage p0: frame FSM and shifters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= byte_end;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            tx_shift <= load_byte(buf_full, buf_data);
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (byte_end) tx_shift <= load_byte(buf_full, buf_data);
          end else if (sclk_fall && bit_cnt != '0) begin
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: publish the completed byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= vld_p1;
      if (vld_p1) rx_data <= rx_shift;
    end
  end

  assign tx_ready = ~buf_full;
  assign busy     = (state == SHIFT);
  assign miso     = (state == SHIFT) & tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: single/multi-byte frames, underrun, abort, reset mid-frame.
module tb_spi_slave;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int rxv_cnt = 0;
  int un_cnt = 0;
  int rv_cyc = 0;
  int last_rise_cyc = 0;
  logic [7:0] rx_log [0:63];

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rxv_cnt < 64) rx_log[rxv_cnt] = rx_data;
      rxv_cnt = rxv_cnt + 1;
      rv_cyc  = cyc;
    end
    if (tx_underrun) un_cnt = un_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_start();
    cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_end();
    tick(4);
    cs = 1'b1;
    tick(8);
  endtask

  // Master side of mode 0: mosi set in the low phase, miso sampled late in the high phase.
  task automatic xfer_bits(input logic [7:0] m, input int nbits, input int half,
                           output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = m[7-i];
      tick(half);
      sclk = 1'b1;
      if (i == nbits - 1) last_rise_cyc = cyc;
      tick(half);
      s = {s[6:0], miso};
      sclk = 1'b0;
    end
    tick(half);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b expected 0", tx_underrun); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b expected 0", miso); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick(8);
  endtask

  task automatic test_single_byte();
    logic [7:0] s;
    int v0, u0;
    write_buf(8'hA5);
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL single_ready_full: got %b expected 0", tx_ready); end
    v0 = rxv_cnt; u0 = un_cnt;
    cs_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL single_ready_empty: got %b expected 1", tx_ready); end
    tests++; if (un_cnt - u0 !== 0) begin fails++; $display("FAIL single_underrun: got %0d expected 0", un_cnt - u0); end
    xfer_bits(8'h3C, 8, 2, s);
    cs_end();
    tests++; if (s !== 8'hA5) begin fails++; $display("FAIL single_miso: got %h expected a5", s); end
    tests++; if (rxv_cnt - v0 !== 1) begin fails++; $display("FAIL single_rxv_count: got %0d expected 1", rxv_cnt - v0); end
    tests++; if (rx_log[v0] !== 8'h3C) begin fails++; $display("FAIL single_rx_log: got %h expected 3c", rx_log[v0]); end
    tests++; if (rv_cyc - last_rise_cyc !== SYNC + 3) begin fails++; $display("FAIL single_latency: got %0d expected %0d", rv_cyc - last_rise_cyc, SYNC + 3); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    tick(10);
    tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_hold: got %h expected 3c", rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s1, s2;
    int v0;
    write_buf(8'hA5);
    v0 = rxv_cnt;
    cs_start();
    write_buf(8'h5A);
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_refill: got %b expected 0", tx_ready); end
    xfer_bits(8'h01, 8, 2, s1);
    xfer_bits(8'h80, 8, 2, s2);
    cs_end();
    tests++; if (s1 !== 8'hA5) begin fails++; $display("FAIL b2b_miso0: got %h expected a5", s1); end
    tests++; if (s2 !== 8'h5A) begin fails++; $display("FAIL b2b_miso1: got %h expected 5a", s2); end
    tests++; if (rxv_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_rxv_count: got %0d expected 2", rxv_cnt - v0); end
    tests++; if (rx_log[v0] !== 8'h01) begin fails++; $display("FAIL b2b_rx0: got %h expected 01", rx_log[v0]); end
    tests++; if (rx_log[v0+1] !== 8'h80) begin fails++; $display("FAIL b2b_rx1: got %h expected 80", rx_log[v0+1]); end
  endtask

  task automatic test_underrun();
    logic [7:0] s;
    int u0;
    u0 = un_cnt;
    cs_start();
    tests++; if (un_cnt - u0 !== 1) begin fails++; $display("FAIL underrun_pulse: got %0d expected 1", un_cnt - u0); end
    xfer_bits(8'hC6, 8, 3, s);
    cs_end();
    tests++; if (s !== 8'h00) begin fails++; $display("FAIL underrun_fill: got %h expected 00", s); end
    tests++; if (rx_data !== 8'hC6) begin fails++; $display("FAIL underrun_rx: got %h expected c6", rx_data); end
    // The end-of-byte reload also finds the buffer empty.
    tests++; if (un_cnt - u0 !== 2) begin fails++; $display("FAIL underrun_total: got %0d expected 2", un_cnt - u0); end
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL underrun_idle_miso: got %b expected 0", miso); end
  endtask

  task automatic test_abort();
    logic [7:0] s;
    int v0;
    v0 = rxv_cnt;
    cs_start();
    xfer_bits(8'hAA, 5, 3, s);
    tick(2);
    cs = 1'b1;
    tick(8);
    tests++; if (rxv_cnt - v0 !== 0) begin fails++; $display("FAIL abort_no_rxv: got %0d expected 0", rxv_cnt - v0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    tests++; if (rx_data !== 8'hC6) begin fails++; $display("FAIL abort_rx_hold: got %h expected c6", rx_data); end
    cs_start();
    xfer_bits(8'hFF, 8, 3, s);
    cs_end();
    tests++; if (rxv_cnt - v0 !== 1) begin fails++; $display("FAIL abort_next_count: got %0d expected 1", rxv_cnt - v0); end
    tests++; if (rx_data !== 8'hFF) begin fails++; $display("FAIL abort_next_rx: got %h expected ff", rx_data); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s;
    int v0;
    cs_start();
    xfer_bits(8'h55, 3, 3, s);
    reset = 1'b1;
    tick(2);
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL midrst_tx_ready: got %b expected 1", tx_ready); end
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL midrst_miso: got %b expected 0", miso); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
    reset = 1'b0;
    tick(8);
    v0 = rxv_cnt;
    xfer_bits(8'h96, 8, 3, s);
    tick(4);
    tests++; if (rxv_cnt - v0 !== 0) begin fails++; $display("FAIL midrst_ignored: got %0d expected 0", rxv_cnt - v0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_still_idle: got %b expected 0", busy); end
    cs = 1'b1;
    tick(8);
    cs_start();
    xfer_bits(8'h69, 8, 3, s);
    cs_end();
    tests++; if (rxv_cnt - v0 !== 1) begin fails++; $display("FAIL midrst_next_count: got %0d expected 1", rxv_cnt - v0); end
    tests++; if (rx_data !== 8'h69) begin fails++; $display("FAIL midrst_next_rx: got %h expected 69", rx_data); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] s1, s2;
    int u0;
    u0 = un_cnt;
    cs = 1'b0;
    // Three edges later the detected cs fall is acted on; the write lands on that same edge.
    tick(3);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL same_write_stored: got %b expected 0", tx_ready); end
    tick(1);
    tests++; if (un_cnt - u0 !== 1) begin fails++; $display("FAIL same_underrun: got %0d expected 1", un_cnt - u0); end
    tick(1);
    xfer_bits(8'h11, 8, 3, s1);
    xfer_bits(8'h22, 8, 3, s2);
    cs_end();
    tests++; if (s1 !== 8'h00) begin fails++; $display("FAIL same_first_byte: got %h expected 00", s1); end
    tests++; if (s2 !== 8'hC3) begin fails++; $display("FAIL same_second_byte: got %h expected c3", s2); end
    tests++; if (rx_data !== 8'h22) begin fails++; $display("FAIL same_rx: got %h expected 22", rx_data); end
  endtask

  initial begin
    reset    = 1'b1;
    sclk     = 1'b0;
    cs       = 1'b1;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk, cs and mosi; legal values are 2 and 3.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 sclk  input  1  serial clock from the master; asynchronous to clk; idles low (mode 0).
REQ-005 cs  input  1  chip select from the master; active low; asynchronous.
REQ-006 mosi  input  1  master-out slave-in data; asynchronous.
REQ-007 miso  output  1  slave-out master-in data; MSB first.
REQ-008 tx_data  input  8  next byte to send to the master.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_ready  output  1  transmit buffer is empty; a write is accepted when tx_valid and tx_ready are both high.
REQ-011 rx_data  output  8  last complete received byte.
REQ-012 rx_valid  output  1  one-cycle pulse; rx_data has just been updated.
REQ-013 tx_underrun  output  1  one-cycle pulse; a byte load found the transmit buffer empty.
REQ-014 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-015 sclk, cs and mosi SHALL each pass through a SYNC_STAGES flop synchronizer before use.
- Edges are detected by comparing the synchronized value with its one-cycle-delayed copy.
REQ-016 FSM states SHALL be exactly two:
- IDLE: cs_s high.
- SHIFT: cs_s low.
REQ-017 Transition IDLE->SHIFT on a synchronized cs falling edge. On that same cycle:
- bit_cnt=0.
- tx_shift loads the buffer byte, or 8'h00 if the buffer is empty; an empty buffer also pulses tx_underrun.
- The buffer is marked empty.
REQ-018 In SHIFT, on a synchronized sclk rising edge:
- rx_shift={rx_shift[6:0],mosi_s}.
- bit_cnt increments modulo 8.
REQ-019 When that rising edge completes bit 7 (bit_cnt 7->0):
- rx_data={rx_shift[6:0],mosi_s} and rx_valid=1 on the next cycle for exactly one cycle.
- tx_shift reloads from the buffer per REQ-017, which supports multi-byte frames.
REQ-020 In SHIFT, on a synchronized sclk falling edge with bit_cnt!=0, tx_shift SHALL shift left by one; when bit_cnt==0 it SHALL NOT shift.
REQ-021 miso SHALL equal tx_shift[7] in SHIFT and 0 in IDLE.
REQ-022 A synchronized cs rising edge in SHIFT SHALL return the FSM to IDLE in the same cycle.
- The partial byte is discarded with no rx_valid.
- bit_cnt is cleared.
- The buffer is untouched.
REQ-023 Latency: rx_valid SHALL rise exactly SYNC_STAGES+2 clk rising edges after the first clk edge that samples the 8th sclk rising edge high.
REQ-024 Legal operation requires each sclk high phase and low phase to last at least SYNC_STAGES clk cycles, and cs to be stable for at least 2 clk cycles around sclk edges.
REQ-025 Buffer write and buffer load in the same cycle with the buffer empty:
- The load uses 8'h00 and pulses tx_underrun.
- The write is stored for the next byte.
- There is no bypass.
REQ-026 rx_data SHALL hold its value until the next completed byte.
REQ-027 busy SHALL be high exactly when the state is SHIFT.

Reset
REQ-028 With reset high at a clk edge, the block SHALL set:
- state=IDLE.
- rx_data=8'h00, rx_valid=0, tx_underrun=0.
- tx_ready=1 (buffer empty), miso=0, busy=0.
- bit_cnt=0, rx_shift=0, tx_shift=0.
REQ-029 Synchronizer flops SHALL reset to idle line levels (sclk 0, cs 1, mosi 0) so that no false edge is detected after reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame. The next frame starts only after a cs rising edge followed by a cs falling edge.

Structure
REQ-031 Package spi_pkg SHALL hold:
- the state encodings IDLE and SHIFT;
- FILL_BYTE=8'h00;
- BYTE_W=8 and CNT_W=3.
REQ-032 Sub-module spi_sync_edge (synchronizer plus rise/fall detect) SHALL be instantiated once each for sclk and cs; mosi uses only a synchronizer.

Verification
REQ-033 Write tx_data=8'hA5; master sends 8'h3C with sclk phases of 2 clk cycles -> master reads 8'hA5, and rx_data=8'h3C with a single rx_valid pulse.
REQ-034 Two-byte frame, buffer refilled with 8'h5A after the first load; master sends 8'h01 then 8'h80 -> miso returns 8'hA5 then 8'h5A, with two rx_valid pulses.
REQ-035 No buffer write, then cs falls -> tx_underrun pulses once, miso returns 8'h00, and the received byte is still captured.
REQ-036 cs deasserted after 5 sclk rising edges -> no rx_valid, busy drops, and the next full frame of 8'hFF is received correctly.
REQ-037 reset pulsed after 3 bits with cs held low -> all outputs at reset values; no reception until cs toggles high then low.
REQ-038 tx_valid asserted on the same cycle the cs falling edge is detected, buffer empty -> first byte is 8'h00, and the second byte equals the written data.
